// File: rtl/fmv_frame_queue.sv
// fmv_frame_queue: display-order frame buffer manager between FMV decoder and frame player
module fmv_frame_queue #(
  parameter int NUM_BUFFERS = 4,
  parameter logic [28:0] BASE_ADR = 29'h0,
  parameter logic [28:0] Y_SIZE = 29'd110592,
  parameter logic [28:0] C_SIZE = 29'd27648,
  parameter logic [28:0] BUF_STRIDE = 29'd165888,
  localparam int IW = $clog2(NUM_BUFFERS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req,
  output logic          alloc_grant,
  output logic [28:0]   alloc_y_adr,
  output logic [28:0]   alloc_u_adr,
  output logic [28:0]   alloc_v_adr,
  input  logic          commit,
  input  logic          abort,
  input  logic          flush,
  input  logic          pause,
  input  logic          vblank,
  output logic [28:0]   frame_y_adr,
  output logic [28:0]   frame_u_adr,
  output logic [28:0]   frame_v_adr,
  output logic          latch_frame,
  output logic          frame_valid,
  output logic [IW:0]   queued_count,
  output logic [IW:0]   free_count,
  output logic          commit_error
);
  typedef enum logic [1:0] {FREE, DECODING, QUEUED, DISPLAYED} bstate_t;
  bstate_t st [NUM_BUFFERS];
  bstate_t st_n [NUM_BUFFERS];
  logic [IW-1:0] fifo [NUM_BUFFERS];
  logic [IW-1:0] rd_ptr, wr_ptr, rd_n, dec_idx, free_idx, disp_idx, head;
  logic [IW:0] q_cnt, q_n, free_n, n_dec, n_q, n_disp;
  logic vblank_q, dec_any, free_any, do_alloc, do_commit, do_abort, do_swap;
  function automatic logic [28:0] y_of(input logic [IW-1:0] i);
    return BASE_ADR + 29'(i) * BUF_STRIDE;
  endfunction
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return p == IW'(NUM_BUFFERS - 1) ? '0 : p + 1'b1;
  endfunction
  assign queued_count = q_cnt;
  assign head = fifo[rd_ptr];
  always_comb begin
    dec_any = 1'b0;
    dec_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    n_dec = '0;
    n_q = '0;
    n_disp = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (st[i] == DECODING) begin
        dec_any = 1'b1;
        dec_idx = IW'(i);
      end
      if (st[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      n_dec = n_dec + (IW+1)'(st[i] == DECODING);
      n_q = n_q + (IW+1)'(st[i] == QUEUED);
      n_disp = n_disp + (IW+1)'(st[i] == DISPLAYED);
    end
    do_alloc = alloc_req && !dec_any && free_any;
    do_commit = commit && dec_any;
    do_abort = abort && dec_any && !commit;
    // flush wins over a swap edge; decisions all use start-of-cycle state
    do_swap = vblank && !vblank_q && !pause && q_cnt != '0 && !flush;
    free_n = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      st_n[i] = st[i];
      if (flush && st[i] == QUEUED) st_n[i] = FREE;
      if (do_swap && IW'(i) == head) st_n[i] = DISPLAYED;
      if (do_swap && frame_valid && IW'(i) == disp_idx) st_n[i] = FREE;
      if (do_commit && IW'(i) == dec_idx) st_n[i] = QUEUED;
      if (do_abort && IW'(i) == dec_idx) st_n[i] = FREE;
      if (do_alloc && IW'(i) == free_idx) st_n[i] = DECODING;
      free_n = free_n + (IW+1)'(st_n[i] == FREE);
    end
    q_n = flush ? (IW+1)'(do_commit) : q_cnt + (IW+1)'(do_commit) - (IW+1)'(do_swap);
    rd_n = flush ? wr_ptr : do_swap ? inc(rd_ptr) : rd_ptr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) st[i] <= FREE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_cnt <= '0;
      vblank_q <= 1'b0;
      disp_idx <= '0;
      frame_valid <= 1'b0;
      alloc_grant <= 1'b0;
      latch_frame <= 1'b0;
      commit_error <= 1'b0;
      free_count <= (IW+1)'(NUM_BUFFERS);
      alloc_y_adr <= BASE_ADR;
      alloc_u_adr <= BASE_ADR + Y_SIZE;
      alloc_v_adr <= BASE_ADR + Y_SIZE + C_SIZE;
      frame_y_adr <= BASE_ADR;
      frame_u_adr <= BASE_ADR + Y_SIZE;
      frame_v_adr <= BASE_ADR + Y_SIZE + C_SIZE;
    end else begin
      for (int i = 0; i < NUM_BUFFERS; i++) st[i] <= st_n[i];
      if (do_commit) begin
        fifo[wr_ptr] <= dec_idx;
        wr_ptr <= inc(wr_ptr);
      end
      rd_ptr <= rd_n;
      q_cnt <= q_n;
      free_count <= free_n;
      vblank_q <= vblank;
      alloc_grant <= do_alloc;
      latch_frame <= do_swap;
      commit_error <= commit && !dec_any;
      if (do_alloc) begin
        alloc_y_adr <= y_of(free_idx);
        alloc_u_adr <= y_of(free_idx) + Y_SIZE;
        alloc_v_adr <= y_of(free_idx) + Y_SIZE + C_SIZE;
      end
      if (do_swap) begin
        disp_idx <= head;
        frame_valid <= 1'b1;
        frame_y_adr <= y_of(head);
        frame_u_adr <= y_of(head) + Y_SIZE;
        frame_v_adr <= y_of(head) + Y_SIZE + C_SIZE;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset)
      assert (n_dec <= 1 && n_disp <= 1 && n_q == q_cnt &&
              free_count + n_dec + n_q + n_disp == (IW+1)'(NUM_BUFFERS));
endmodule

// File: tb/tb_fmv_frame_queue.sv
// tb_fmv_frame_queue: directed scoreboard bench for the display-order frame queue
module tb_fmv_frame_queue;
  logic clk = 0, reset = 1, alloc_req = 0, commit = 0, abort = 0, flush = 0, pause = 0, vblank = 0;
  logic alloc_grant, latch_frame, frame_valid, commit_error;
  logic [28:0] alloc_y_adr, alloc_u_adr, alloc_v_adr, frame_y_adr, frame_u_adr, frame_v_adr;
  logic [2:0] queued_count, free_count;
  int total = 0, bad = 0, err_pending = 0;
  logic [28:0] gq[$], lq[$];
  localparam logic [28:0] B0 = 29'd0, B1 = 29'd165888, B2 = 29'd331776, B3 = 29'd497664;
  localparam logic [28:0] YS = 29'd110592, UVS = 29'd138240;
  fmv_frame_queue dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_grant(alloc_grant),
    .alloc_y_adr(alloc_y_adr), .alloc_u_adr(alloc_u_adr), .alloc_v_adr(alloc_v_adr),
    .commit(commit), .abort(abort), .flush(flush), .pause(pause), .vblank(vblank),
    .frame_y_adr(frame_y_adr), .frame_u_adr(frame_u_adr), .frame_v_adr(frame_v_adr),
    .latch_frame(latch_frame), .frame_valid(frame_valid), .queued_count(queued_count),
    .free_count(free_count), .commit_error(commit_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (alloc_grant) begin
        chk("grant_expected", 32'(gq.size() != 0), 1);
        if (gq.size() != 0) begin
          logic [28:0] y;
          y = gq.pop_front();
          chk("alloc_y", alloc_y_adr, y);
          chk("alloc_u", alloc_u_adr, y + YS);
          chk("alloc_v", alloc_v_adr, y + UVS);
        end
      end
      if (latch_frame) begin
        chk("latch_expected", 32'(lq.size() != 0), 1);
        if (lq.size() != 0) begin
          logic [28:0] y;
          y = lq.pop_front();
          chk("frame_y", frame_y_adr, y);
          chk("frame_u", frame_u_adr, y + YS);
          chk("frame_v", frame_v_adr, y + UVS);
        end
      end
      if (commit_error) begin
        chk("error_expected", 32'(err_pending != 0), 1);
        if (err_pending != 0) err_pending--;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input logic [28:0] y);
    gq.push_back(y);
    alloc_req = 1;
    tick;
    alloc_req = 0;
    tick;
  endtask
  task automatic cmt;
    commit = 1;
    tick;
    commit = 0;
    tick;
  endtask
  task automatic vb(input bit sw, input logic [28:0] y);
    if (sw) lq.push_back(y);
    vblank = 1;
    tick;
    vblank = 0;
    tick;
  endtask
  task automatic counts(input string name, input int q, input int f);
    chk({name, "_queued"}, 32'(queued_count), q);
    chk({name, "_free"}, 32'(free_count), f);
  endtask
  initial begin
    repeat (3) tick;
    counts("reset", 0, 4);
    chk("reset_valid", 32'(frame_valid), 0);
    chk("reset_frame_y", frame_y_adr, 0);
    chk("reset_alloc_v", alloc_v_adr, UVS);
    chk("reset_grant", 32'(alloc_grant), 0);
    reset = 0;
    tick;
    alloc(B0);
    counts("alloc0", 0, 3);
    cmt;
    alloc(B1);
    cmt;
    counts("two_queued", 2, 2);
    vb(1, B0);
    counts("first_swap", 1, 2);
    chk("valid_after_swap", 32'(frame_valid), 1);
    vb(1, B1);
    counts("second_swap", 0, 3);
    chk("frame_after_second", frame_y_adr, B1);
    alloc(B0); cmt;
    alloc(B2); cmt;
    alloc(B3); cmt;
    counts("full", 3, 0);
    alloc_req = 1;
    repeat (3) tick;
    chk("full_no_grant", 32'(alloc_grant), 0);
    gq.push_back(B1);
    lq.push_back(B0);
    vblank = 1;
    tick;
    chk("no_same_cycle_grant", 32'(alloc_grant), 0);
    vblank = 0;
    tick;
    chk("grant_after_free", 32'(alloc_grant), 1);
    alloc_req = 0;
    tick;
    counts("after_refill", 2, 0);
    pause = 1;
    vb(0, 0); vb(0, 0); vb(0, 0);
    chk("paused_frame", frame_y_adr, B0);
    counts("paused", 2, 0);
    pause = 0;
    vb(1, B2);
    counts("unpaused", 1, 1);
    cmt;
    counts("commit_buf1", 2, 1);
    err_pending++;
    commit = 1;
    tick;
    chk("commit_error_pulse", 32'(commit_error), 1);
    commit = 0;
    tick;
    counts("bad_commit", 2, 1);
    alloc(B0);
    counts("alloc_before_abort", 2, 0);
    abort = 1; tick; abort = 0; tick;
    counts("abort", 2, 1);
    abort = 1; tick; abort = 0; tick;
    counts("idle_abort", 2, 1);
    vb(1, B3);
    vb(1, B1);
    counts("drained", 0, 3);
    alloc(B0);
    commit = 1;
    vblank = 1;
    tick;
    chk("commit_edge_no_latch", 32'(latch_frame), 0);
    counts("commit_edge", 1, 2);
    commit = 0;
    vblank = 0;
    tick;
    vb(1, B0);
    counts("committed_shown", 0, 3);
    alloc(B1); cmt;
    alloc(B2); cmt;
    counts("pre_flush", 2, 1);
    flush = 1; tick; flush = 0; tick;
    counts("flush", 0, 3);
    chk("flush_frame_held", frame_y_adr, B0);
    vb(0, 0);
    chk("empty_edge_held", frame_y_adr, B0);
    alloc(B1); cmt;
    alloc(B2);
    flush = 1; commit = 1; tick; flush = 0; commit = 0; tick;
    counts("flush_commit", 1, 2);
    vb(1, B2);
    counts("survivor_shown", 0, 3);
    alloc(B0); cmt;
    flush = 1;
    vblank = 1;
    tick;
    chk("flush_edge_no_latch", 32'(latch_frame), 0);
    flush = 0;
    vblank = 0;
    tick;
    counts("flush_edge", 0, 3);
    chk("flush_edge_frame", frame_y_adr, B2);
    alloc(B0);
    reset = 1;
    tick;
    counts("mid_decode_reset", 0, 4);
    chk("reset_clears_valid", 32'(frame_valid), 0);
    tick;
    chk("no_grant_in_reset", 32'(alloc_grant), 0);
    reset = 0;
    tick;
    chk("grants_left", gq.size(), 0);
    chk("latches_left", lq.size(), 0);
    chk("errors_left", err_pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
